// File: rtl/cola_pkg.sv
// Shared definitions for the cola dispenser: state encoding and default timing/queue constants.
package cola_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MOTOR     = 2'd1,
      WAIT_DROP = 2'd2,
      ERR       = 2'd3
   } state_e;

   localparam int MOTOR_CYC_DEF   = 50;
   localparam int TIMEOUT_CYC_DEF = 1000;
   localparam int PEND_MAX_DEF    = 7;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchronizer for an asynchronous level, followed by a one-cycle rising-edge pulse.
module sync_rise (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic async_i,
   output logic rise_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/cola_dispense.sv
// Cola dispenser controller: queues vend requests, runs the motor, waits for the can-drop
// sensor and parks in ERR on a missing drop until cleared. po_state mirrors the FSM state.
module cola_dispense
   import cola_pkg::*;
#(
   parameter int MOTOR_CYC   = MOTOR_CYC_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int PEND_MAX    = PEND_MAX_DEF
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       pi_vend,
   input  logic       pi_drop_sensor,
   input  logic       pi_err_clr,
   output logic       po_motor,
   output logic       po_done,
   output logic       po_lost,
   output logic       po_err,
   output logic [3:0] po_pend,
   output logic [1:0] po_state
);

   localparam int TMR_MAX = max2(MOTOR_CYC, TIMEOUT_CYC);
   localparam int TW      = $clog2(TMR_MAX + 1);

   localparam logic [TW-1:0] MOTOR_LAST   = TW'(MOTOR_CYC - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [3:0]    PEND_LIM     = 4'(PEND_MAX);

   state_e        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [3:0]    pend_q, pend_d;
   logic          motor_q, motor_d;
   logic          done_q, done_d;
   logic          lost_q, lost_d;
   logic          err_q, err_d;
   logic          start;
   logic          drop_rise;

   sync_rise u_sync_rise (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .async_i (pi_drop_sensor),
      .rise_o  (drop_rise)
   );

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      start   = 1'b0;
      case (state_q)
         IDLE: begin
            if (pend_q != 4'd0) begin
               state_d = MOTOR;
               start   = 1'b1;
            end
         end
         MOTOR: begin
            if (timer_q == MOTOR_LAST) state_d = WAIT_DROP;
         end
         WAIT_DROP: begin
            // The drop edge is checked first so it wins over a same-cycle timeout.
            if (drop_rise) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else if (timer_q == TIMEOUT_LAST) begin
               state_d = ERR;
            end
         end
         ERR: begin
            if (pi_err_clr) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      timer_d = '0;
      if (state_d == state_q && (state_q == MOTOR || state_q == WAIT_DROP)) begin
         timer_d = timer_q + 1'b1;
      end
   end

   always_comb begin
      pend_d = pend_q;
      lost_d = 1'b0;
      if (pi_vend && !start) begin
         if (pend_q == PEND_LIM) lost_d = 1'b1;
         else                    pend_d = pend_q + 4'd1;
      end else if (!pi_vend && start) begin
         pend_d = pend_q - 4'd1;
      end
   end

   // Outputs are registered from next-state so they line up with the state they describe.
   always_comb begin
      motor_d = (state_d == MOTOR);
      err_d   = (state_d == ERR);
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q <= IDLE;
         timer_q <= '0;
         pend_q  <= 4'd0;
         motor_q <= 1'b0;
         done_q  <= 1'b0;
         lost_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         pend_q  <= pend_d;
         motor_q <= motor_d;
         done_q  <= done_d;
         lost_q  <= lost_d;
         err_q   <= err_d;
      end
   end

   assign po_motor = motor_q;
   assign po_done  = done_q;
   assign po_lost  = lost_q;
   assign po_err   = err_q;
   assign po_pend  = pend_q;
   assign po_state = state_q;

endmodule

// File: doc/cola_dispense.md
COLA_DISPENSE -- requirements
Module: cola_dispense

Interface
REQ-001 Parameter MOTOR_CYC, default 50, number of cycles the motor output is held high per vend.
REQ-002 Parameter TIMEOUT_CYC, default 1000, number of cycles allowed for a drop-sensor edge after motor-off.
REQ-003 Parameter PEND_MAX, default 7, maximum queued vend requests; range 1..15.
REQ-004 sys_clk  in  1  single system clock; all logic on rising edge.
REQ-005 sys_rst  in  1  asynchronous, active-high reset.
REQ-006 pi_vend  in  1  one-cycle vend request pulse, synchronous to sys_clk; each high cycle counts as one request.
REQ-007 pi_drop_sensor  in  1  asynchronous can-drop sensor, active high; level may persist.
REQ-008 pi_err_clr  in  1  synchronous one-cycle error-clear pulse.
REQ-009 po_motor  out  1  dispenser motor enable.
REQ-010 po_done  out  1  one-cycle pulse when a drop is confirmed.
REQ-011 po_lost  out  1  one-cycle pulse when a request is discarded because the queue is full.
REQ-012 po_err  out  1  high while in the ERR state.
REQ-013 po_pend  out  4  current queued request count.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 The state machine SHALL have four states: IDLE, MOTOR, WAIT_DROP, ERR.
REQ-016 Pending count rules:
- pi_vend increments the count.
- Leaving IDLE for MOTOR decrements it.
- Both in the same cycle leave the count unchanged.
- The count never exceeds PEND_MAX and never goes below 0.
REQ-017 pi_vend arriving with the count at PEND_MAX and no same-cycle decrement SHALL leave the count unchanged and pulse po_lost for one cycle.
REQ-018 IDLE -> MOTOR on a clock edge where the count is >0 before that edge.
- A pi_vend sampled at edge N with the count at 0 gives po_motor high after edge N+1.
REQ-019 MOTOR: po_motor=1 for exactly MOTOR_CYC cycles, then WAIT_DROP with po_motor=0.
REQ-020 WAIT_DROP: a synchronized rising edge of pi_drop_sensor -> IDLE with a one-cycle po_done.
- Sensor edges outside WAIT_DROP are ignored.
REQ-021 WAIT_DROP: TIMEOUT_CYC cycles without an edge -> ERR, with po_err=1 from the next cycle.
REQ-022 If the edge and the timeout occur on the same cycle, the edge SHALL win (-> IDLE, po_done).
REQ-023 ERR: po_motor=0; pi_vend is still queued (REQ-016/017 apply); pi_err_clr -> IDLE; pi_err_clr in any other state is ignored.
REQ-024 Back-to-back requests: after po_done, the next vend SHALL start one cycle later if the count is >0.
REQ-025 The cycle timer SHALL clear on every state entry and be wide enough for max(MOTOR_CYC, TIMEOUT_CYC).
REQ-026 pi_drop_sensor SHALL pass through a two-flop synchronizer before edge detection, adding 2 cycles of latency.

Reset
REQ-027 Asserting sys_rst SHALL immediately force:
- state IDLE, pending count 0, timer 0, synchronizer flops 0;
- po_motor=0, po_done=0, po_lost=0, po_err=0, po_pend=0.
REQ-028 Reset mid-vend SHALL drop the motor at once and discard all queued requests.
REQ-029 After deassertion, the first pi_vend SHALL be accepted on the first rising edge.

Structure
REQ-030 Shared package cola_pkg SHALL hold:
- the state encoding (IDLE=2'd0, MOTOR=2'd1, WAIT_DROP=2'd2, ERR=2'd3);
- default constants for MOTOR_CYC, TIMEOUT_CYC and PEND_MAX.
REQ-031 One sub-module, sync_rise, SHALL implement the two-flop synchronizer plus a one-cycle rising-edge pulse, with the same clock/reset ports.

Verification (bench parameters MOTOR_CYC=4, TIMEOUT_CYC=20, PEND_MAX=7)
REQ-032 Single vend, sensor raised 3 cycles after motor-off -> po_motor high 4 cycles, po_done 1 pulse, po_pend 1->0, po_err=0.
REQ-033 9 consecutive pi_vend pulses while busy -> po_pend saturates at 7, po_lost pulses at least once, and exactly 1+7 vends complete with the sensor toggled each time.
REQ-034 Vend with the sensor held low -> po_err=1 at 20 cycles after motor-off; 2 pi_vend in ERR -> po_pend=2; pi_err_clr -> next vend starts, po_pend 2->1.
REQ-035 pi_vend on the same edge as IDLE->MOTOR with the count at 1 -> po_pend stays 1, and a second vend follows.
REQ-036 sys_rst asserted mid-MOTOR with po_pend=3 -> po_motor=0 and po_pend=0 without a clock edge; after release, no motor activity until a new pi_vend.
REQ-037 Sensor pulse during MOTOR only -> ignored, timeout to ERR at 20 cycles after motor-off.
